// File: rtl/sigmoid_inverse_8bit.sv
// Sequential inverse of the 8-bit sigmoid: a bitwise binary search that finds the smallest
// signed x with sigmoid_8bit(x) >= y, using one combinational sigmoid_8bit probe per clock.

// Piecewise-linear sigmoid (PLAN segments), x in Q3.4, y scaled by 1024.
// Positive side saturates at 1020, so codes above 1020 are unreachable.
module sigmoid_8bit (
    input  logic [7:0] x,
    output logic [9:0] y
);
    logic [7:0]  a;
    logic [10:0] u;

    always_comb begin
        a = x[7] ? (~x + 8'd1) : x;
        if (a < 8'd16)
            u = 11'd512 + {3'b0, a[3:0], 4'b0};
        else if (a < 8'd38)
            u = 11'd640 + {2'b0, a[5:0], 3'b0};
        else if (a < 8'd80)
            u = 11'd864 + {3'b0, a[6:0], 1'b0};
        else
            u = 11'd1024;
        // Negative side mirrors as 1024 - u; u = 1024 wraps to exactly 0 in 10 bits
        if (x[7])
            y = 10'd0 - u[9:0];
        else
            y = (u > 11'd1020) ? 10'd1020 : u[9:0];
    end
endmodule

module sigmoid_inverse_8bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_x,
    output logic        out_sat,
    output logic        busy
);
    localparam int X_W = 8;
    localparam int Y_W = 10;

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t         state, state_n;
    logic [8:0]     cnt, cnt_n;
    logic [3:0]     b, b_n;
    logic [Y_W-1:0] y_r, y_n;
    logic [X_W-1:0] x_n;
    logic           sat_n;
    logic [9:0]     cand;
    logic [X_W-1:0] probe_x;
    logic [Y_W-1:0] probe_y;
    logic           take;

    sigmoid_8bit u_sig (
        .x (probe_x),
        .y (probe_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 9'd0;
            b       <= 4'd8;
            y_r     <= '0;
            out_x   <= '0;
            out_sat <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            b       <= b_n;
            y_r     <= y_n;
            out_x   <= x_n;
            out_sat <= sat_n;
        end
    end

    // cnt counts candidates known to sit below y_r; candidate c maps to x = c - 1 - 128
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        b_n     = b;
        y_n     = y_r;
        x_n     = out_x;
        sat_n   = out_sat;
        cand    = {1'b0, cnt} + (10'd1 << b);
        probe_x = (cand[7:0] - 8'd1) ^ 8'h80;
        take    = (cand <= 10'd256) && (probe_y < y_r);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    y_n     = in_y;
                    cnt_n   = 9'd0;
                    b_n     = 4'd8;
                    state_n = SEARCH;
                end
            end
            SEARCH: begin
                if (take)
                    cnt_n = cand[8:0];
                if (b == 4'd0) begin
                    state_n = DONE;
                    sat_n   = cnt_n[8];
                    x_n     = cnt_n[8] ? 8'h7F : (cnt_n[7:0] ^ 8'h80);
                end else begin
                    b_n = b - 4'd1;
                end
            end
            DONE: begin
                if (out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
endmodule

// File: doc/sigmoid_inverse_8bit.md
Name: sigmoid_inverse_8bit

Overview:
Sequential inverse of sigmoid_8bit. Takes a 10-bit sigmoid output code y and returns the smallest signed 8-bit x with sigmoid_8bit(x) >= y. The search is a bitwise binary search over one internal combinational sigmoid_8bit instance. The block sits after the activation path and recovers pre-activation values for calibration and round-trip checking of the sigmoid units. It relies only on the sigmoid_8bit transfer function being non-decreasing in signed x.

Parameters:
X_W, 8, input width of sigmoid_8bit; fixed, must not be overridden.
Y_W, 10, output width of sigmoid_8bit; fixed, must not be overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_y valid
in_ready  output  1  block can accept; high only in IDLE
in_y  input  Y_W  target sigmoid code, unsigned
out_valid  output  1  result valid; held until accepted
out_ready  input  1  downstream accepts result
out_x  output  X_W  signed result x
out_sat  output  1  no x in [-128,127] reaches in_y; out_x = 127
busy  output  1  high in SEARCH or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, out_x=0, out_sat=0, busy=0, cnt=0, bit index=8, y register=0.
- Reset asserted mid-SEARCH or in DONE aborts immediately. A pending result is discarded, and the next request is accepted only after rst_n deasserts.
- FSM states: IDLE, SEARCH, DONE.
- IDLE: in_ready=1. If in_valid is high at a rising edge, latch in_y into y_r, clear cnt (9-bit) to 0, set b=8, and go to SEARCH.
- SEARCH: one probe per clock, b = 8 down to 0.
  - Candidate c = cnt + 2^b.
  - If c <= 256 and sigmoid_8bit(c-1-128) < y_r (unsigned compare), then cnt <= c; otherwise cnt is unchanged.
  - When b = 0, go to DONE and set out_valid=1; otherwise b <= b-1.
  - The sigmoid input is driven from the candidate only; y_r and the sigmoid output are compared in the same cycle, with no pipeline register.
- Latency: always exactly 9 SEARCH cycles, independent of data. out_valid is high after the 9th rising edge following the accepting edge.
- Result at DONE entry:
  - cnt < 256: out_x = cnt - 128 (two's complement), out_sat=0.
  - cnt = 256: out_x = 127, out_sat=1.
- DONE: out_x and out_sat are stable while out_valid=1. If out_ready is high at a rising edge, clear out_valid and go to IDLE. out_x and out_sat keep their last value after clearing.
- No new input is accepted in DONE; in_ready=0 there, so out_ready and in_valid can never complete together.
- in_valid while not in IDLE is ignored; the upstream must hold it until in_ready is seen.
- Throughput: one result per 11 cycles at most (accept, 9 SEARCH, 1 DONE handshake).
- y = 0 always yields cnt = 0 and out_x = -128, since every sigmoid code is >= 0.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release -> in_ready=1, out_valid=0, out_x=8'h00, out_sat=0, busy=0.
- in_y=10'd0 with out_ready=1 -> out_valid exactly 9 cycles after accept, out_x=-128 (8'h80), out_sat=0, in_ready high on the next cycle.
- Round trip over all x0 from -128 to 127: y=sigmoid_8bit(x0) -> out_sat=0, out_x <= x0, and sigmoid_8bit(out_x)==y. Also, if out_x > -128, then sigmoid_8bit(out_x-1) < y.
- in_y=10'h3FF: if sigmoid_8bit(127) < 1023 -> out_x=127 (8'h7F), out_sat=1; otherwise out_sat=0 and out_x is the first x reaching 1023.
- Back-pressure: out_ready=0 for 20 cycles after out_valid -> out_valid, out_x, out_sat constant, in_ready=0, new in_valid pulses ignored. out_ready=1 -> IDLE next cycle.
- Mid-search reset: assert rst_n=0 at SEARCH cycle 4 -> out_valid stays 0, all outputs at reset values. The next request after release (in_y=0) returns -128 with the standard 9-cycle latency.
